// File: rtl/adder_pkg.sv
// Shared widths, saturation limits and entry layout for the adder result path.
// Consumed by result_fifo and sum_collector.
package adder_pkg;

  localparam int DW_DEF    = 32;
  localparam int TW_DEF    = 8;
  localparam int DEPTH_DEF = 4;

  localparam logic signed [DW_DEF-1:0] SAT_MAX = {1'b0, {(DW_DEF-1){1'b1}}};
  localparam logic signed [DW_DEF-1:0] SAT_MIN = {1'b1, {(DW_DEF-1){1'b0}}};

  typedef struct packed {
    logic signed [DW_DEF-1:0] sum;
    logic        [TW_DEF-1:0] tag;
  } entry_t;

endpackage

// File: rtl/result_fifo.sv
// Circular buffer holding {sum, tag} entries; head is read combinationally.
// Pointers wrap modulo DEPTH (power of two); clear flushes synchronously.
module result_fifo
  import adder_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int TW    = TW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clear,
  input  logic            push,
  input  logic            pop,
  input  logic [DW+TW-1:0] wdata,
  output logic [DW+TW-1:0] rdata,
  output logic [CW-1:0]   count,
  output logic            full,
  output logic            empty
);

  logic [DW+TW-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~clear;
  assign do_pop  = pop & ~empty & ~clear;
  assign rdata   = mem[rd_ptr];

  // NOTE: storage has no reset; stale entries are unobservable because
  // out_valid is derived from count, and omitting it keeps mem in plain RAM.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sum_collector.sv
// Collects signed adder results into a FIFO and keeps a running total with a
// sticky overflow flag. Define SUM_COLLECTOR_SAT_EN to saturate the total.
module sum_collector
  import adder_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int TW    = TW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_sum,
  input  logic        [TW-1:0] in_tag,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic signed [DW-1:0] out_sum,
  output logic        [TW-1:0] out_tag,
  input  logic                 out_ready,
  output logic signed [DW-1:0] acc_total,
  output logic        [CW-1:0] count,
  output logic                 ovf
);

  // Limits follow DW so non-default widths saturate at their own bounds.
  localparam logic signed [DW-1:0] SAT_HI = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SAT_LO = {1'b1, {(DW-1){1'b0}}};

  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [DW+TW-1:0]   head;
  logic signed [DW-1:0] raw_sum;
  logic signed [DW-1:0] acc_next;
  logic               add_ovf;

  assign in_ready  = ~full & ~clear;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_sum   = head[DW+TW-1:TW];
  assign out_tag   = head[TW-1:0];

  result_fifo #(.DW(DW), .TW(TW), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .wdata ({in_sum, in_tag}),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    raw_sum  = acc_total + in_sum;
    add_ovf  = (acc_total[DW-1] == in_sum[DW-1]) && (raw_sum[DW-1] != acc_total[DW-1]);
    acc_next = raw_sum;
`ifdef SUM_COLLECTOR_SAT_EN
    if (add_ovf) acc_next = acc_total[DW-1] ? SAT_LO : SAT_HI;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_total <= '0;
      ovf       <= 1'b0;
    end else if (clear) begin
      acc_total <= '0;
      ovf       <= 1'b0;
    end else if (push) begin
      acc_total <= acc_next;
      ovf       <= ovf | add_ovf;
    end
  end

endmodule

// File: tb/tb_sum_collector.sv
// Directed self-checking bench for sum_collector (DW=32, TW=8, DEPTH=4).
// Expected values are hand-computed constants plus a small FIFO queue model.
module tb_sum_collector;

  localparam int DW    = 32;
  localparam int TW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                 clock;
  logic                 reset;
  logic                 clear;
  logic                 in_valid;
  logic signed [DW-1:0] in_sum;
  logic        [TW-1:0] in_tag;
  logic                 in_ready;
  logic                 out_valid;
  logic signed [DW-1:0] out_sum;
  logic        [TW-1:0] out_tag;
  logic                 out_ready;
  logic signed [DW-1:0] acc_total;
  logic        [CW-1:0] count;
  logic                 ovf;

  int vectors;
  int errors;

  sum_collector #(.DW(DW), .TW(TW), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_sum    (in_sum),
    .in_tag    (in_tag),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_tag   (out_tag),
    .out_ready (out_ready),
    .acc_total (acc_total),
    .count     (count),
    .ovf       (ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_one(input logic signed [DW-1:0] s, input logic [TW-1:0] t);
    in_valid = 1'b1;
    in_sum   = s;
    in_tag   = t;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    vectors++;
    if (count !== CW'(0)) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    vectors++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vectors++;
    if (acc_total !== 32'sd0 || ovf !== 1'b0) begin
      errors++; $display("FAIL reset_acc got %0d/%b want 0/0", acc_total, ovf);
    end
  endtask

  task automatic test_fill();
    push_one(32'sd69888, 8'h6b);
    vectors++;
    if (out_valid !== 1'b1 || out_sum !== 32'sd69888 || out_tag !== 8'h6b) begin
      errors++; $display("FAIL first_push_visible got %b/%0d/%h want 1/69888/6b", out_valid, out_sum, out_tag);
    end
    push_one(32'sd6640754, 8'h6b);
    push_one(-32'sd663, 8'h6b);
    push_one(32'sd4, 8'h6b);
    vectors++;
    if (count !== CW'(4)) begin errors++; $display("FAIL fill_count got %0d want 4", count); end
    vectors++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got %b want 0", in_ready); end
    vectors++;
    if (acc_total !== 32'sd6709983) begin errors++; $display("FAIL fill_acc got %0d want 6709983", acc_total); end
    vectors++;
    if (out_sum !== 32'sd69888) begin errors++; $display("FAIL fill_head got %0d want 69888", out_sum); end
  endtask

  task automatic test_full_reject();
    logic signed [DW-1:0] exp_order [4];
    exp_order[0] = 32'sd6640754;
    exp_order[1] = -32'sd663;
    exp_order[2] = 32'sd4;
    exp_order[3] = 32'sd8;
    // Push while full, with a pop request in the same cycle: push must still drop.
    in_valid  = 1'b1;
    in_sum    = 32'sd8;
    in_tag    = 8'h6b;
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    vectors++;
    if (count !== CW'(3) || acc_total !== 32'sd6709983) begin
      errors++; $display("FAIL full_reject got count=%0d acc=%0d want 3/6709983", count, acc_total);
    end
    push_one(32'sd8, 8'h6b);
    vectors++;
    if (count !== CW'(4) || acc_total !== 32'sd6709991) begin
      errors++; $display("FAIL accept_after_pop got count=%0d acc=%0d want 4/6709991", count, acc_total);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_sum !== exp_order[i]) begin
        errors++; $display("FAIL pop_order[%0d] got %b/%0d want 1/%0d", i, out_valid, out_sum, exp_order[i]);
      end
      step();
    end
    // One extra pop on empty must be ignored.
    step();
    out_ready = 1'b0;
    vectors++;
    if (count !== CW'(0) || out_valid !== 1'b0) begin
      errors++; $display("FAIL drain_empty got count=%0d valid=%b want 0/0", count, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int q[$];
    int next_val;
    int sum;
    do_clear();
    sum = 0;
    push_one(32'sd10, 8'h01); q.push_back(10); sum += 10;
    push_one(32'sd20, 8'h02); q.push_back(20); sum += 20;
    next_val = 30;
    for (int i = 0; i < 2 * DEPTH; i++) begin
      vectors++;
      if (out_sum !== DW'(q[0])) begin
        errors++; $display("FAIL b2b_head[%0d] got %0d want %0d", i, out_sum, q[0]);
      end
      in_valid  = 1'b1;
      in_sum    = DW'(next_val);
      in_tag    = 8'(next_val);
      out_ready = 1'b1;
      step();
      void'(q.pop_front());
      q.push_back(next_val);
      sum += next_val;
      next_val += 10;
      vectors++;
      if (count !== CW'(2)) begin errors++; $display("FAIL b2b_count[%0d] got %0d want 2", i, count); end
    end
    in_valid = 1'b0;
    vectors++;
    if (acc_total !== DW'(sum)) begin errors++; $display("FAIL b2b_acc got %0d want %0d", acc_total, sum); end
    while (q.size() > 0) begin
      vectors++;
      if (out_sum !== DW'(q[0]) || out_tag !== 8'(q[0])) begin
        errors++; $display("FAIL b2b_drain got %0d/%h want %0d", out_sum, out_tag, q[0]);
      end
      step();
      void'(q.pop_front());
    end
    out_ready = 1'b0;
    vectors++;
    if (count !== CW'(0)) begin errors++; $display("FAIL b2b_final_count got %0d want 0", count); end
  endtask

  task automatic test_overflow();
    logic signed [DW-1:0] exp_acc;
    do_clear();
    push_one(32'sh7FFFFFFF, 8'h61);
    vectors++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", ovf); end
    push_one(32'sd1, 8'h62);
`ifdef SUM_COLLECTOR_SAT_EN
    exp_acc = 32'sh7FFFFFFF;
`else
    exp_acc = 32'sh80000000;
`endif
    vectors++;
    if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", ovf); end
    vectors++;
    if (acc_total !== exp_acc) begin errors++; $display("FAIL ovf_acc got %h want %h", acc_total, exp_acc); end
    push_one(-32'sd5, 8'h63);
    vectors++;
    if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", ovf); end
  endtask

  task automatic test_async_reset();
    // count is 3 here; assert reset between edges.
    vectors++;
    if (count !== CW'(3)) begin errors++; $display("FAIL pre_reset_count got %0d want 3", count); end
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    vectors++;
    if (count !== CW'(0) || out_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset_fifo got count=%0d valid=%b want 0/0", count, out_valid);
    end
    vectors++;
    if (acc_total !== 32'sd0 || ovf !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset_acc got %0d/%b/%b want 0/0/1", acc_total, ovf, in_ready);
    end
    #3;
    reset = 1'b0;
    push_one(32'sd7, 8'h37);
    vectors++;
    if (count !== CW'(1) || out_sum !== 32'sd7 || acc_total !== 32'sd7) begin
      errors++; $display("FAIL post_reset_push got %0d/%0d/%0d want 1/7/7", count, out_sum, acc_total);
    end
  endtask

  task automatic test_clear();
    push_one(32'sd100, 8'h40);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_sum   = 32'sd55;
    in_tag   = 8'h41;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL clear_in_ready got %b want 0", in_ready); end
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    vectors++;
    if (count !== CW'(0) || acc_total !== 32'sd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL clear_flush got %0d/%0d/%b want 0/0/0", count, acc_total, out_valid);
    end
  endtask

  initial begin
    vectors   = 0;
    errors    = 0;
    reset     = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    #12;
    test_reset();
    reset = 1'b0;
    step();
    test_fill();
    test_full_reject();
    test_back_to_back();
    test_overflow();
    test_async_reset();
    test_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/sum_collector.md
SUM_COLLECTOR -- requirements
Module: sum_collector

Interface
REQ-001 SHALL have parameter DW, default 32, signed sum width.
REQ-002 SHALL have parameter TW, default 8, tag width (tag is the character token carried alongside each sum).
REQ-003 SHALL have parameter DEPTH, default 4, FIFO entries; power of two, 2..16.
REQ-004 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port clear  input  1  synchronous flush of FIFO, accumulator and flag.
REQ-007 SHALL have port in_valid  input  1  upstream adder result present.
REQ-008 SHALL have port in_sum  input  DW  signed sum from the upstream adder.
REQ-009 SHALL have port in_tag  input  TW  token accompanying in_sum.
REQ-010 SHALL have port in_ready  output  1  collector accepts this cycle.
REQ-011 SHALL have port out_valid  output  1  head entry available.
REQ-012 SHALL have port out_sum  output  DW  signed head sum.
REQ-013 SHALL have port out_tag  output  TW  head tag.
REQ-014 SHALL have port out_ready  input  1  downstream consumes head.
REQ-015 SHALL have port acc_total  output  DW  signed running total of all accepted sums.
REQ-016 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-017 SHALL have port ovf  output  1  sticky accumulator overflow flag.

Function
REQ-018 SHALL define push as in_valid & in_ready, and pop as out_valid & out_ready.
REQ-019 SHALL drive in_ready = (count != DEPTH) & ~clear; a full FIFO SHALL NOT accept data in the same cycle as a pop.
REQ-020 SHALL drive out_valid = (count != 0); out_sum/out_tag SHALL show the head entry combinationally from storage.
REQ-021 SHALL make an entry pushed in cycle N visible at the output in cycle N+1; no same-cycle bypass.
REQ-022 SHALL, on a simultaneous push and pop with 0 < count < DEPTH, hold count and advance both pointers.
REQ-023 SHALL wrap the read and write pointers modulo DEPTH; FIFO order SHALL be preserved across wrap.
REQ-024 SHALL ignore a pop when empty and ignore in_valid when full; count SHALL never leave the range 0..DEPTH.
REQ-025 SHALL update acc_total <= acc_total + in_sum on each push, as signed DW-bit addition.
REQ-026 SHALL set ovf when both operands have the same sign and the result sign differs; ovf SHALL stay set until reset or clear.
REQ-027 SHALL, on clear, set count=0, reset both pointers, set acc_total=0 and ovf=0 next cycle; clear SHALL take priority over push and pop.
REQ-028 SHALL leave the contents of popped or flushed storage don't-care; only the head is observable.

Reset
REQ-029 SHALL, on reset assertion, immediately force count=0, pointers=0, acc_total=0, ovf=0, out_valid=0 and in_ready=1 (in_ready=1 only while clear=0).
REQ-030 SHALL, on reset assertion mid-transfer, discard all FIFO contents; the first push after deassertion SHALL behave as on an empty FIFO.

Configuration
REQ-031 SHALL implement saturation selected by macro SUM_COLLECTOR_SAT_EN: when defined, an overflowing accumulation clamps acc_total to 2^(DW-1)-1 or -2^(DW-1) and still sets ovf.
REQ-032 SHALL, when SUM_COLLECTOR_SAT_EN is undefined, let acc_total wrap two's-complement, with ovf set identically.

Structure
REQ-033 SHALL place the DW, TW and DEPTH defaults, the SAT_MAX/SAT_MIN constants and the entry typedef {sum, tag} in shared package adder_pkg.
REQ-034 SHALL implement storage and pointers in sub-module result_fifo; sum_collector SHALL contain only the accumulator, flag and glue logic.

Verification
REQ-035 SHALL verify that pushing (69888,"k"), (6640754,"k"), (-663,"k"), (4,"k") with out_ready=0 gives count=4, in_ready=0, acc_total=6709983, out_sum=69888.
REQ-036 SHALL verify that a 5th push of 8 while full is rejected; after one pop, 8 is accepted; pops then return 6640754, -663, 4, 8 in order, and count=0.
REQ-037 SHALL verify that with count=2 and push and pop in the same cycle, count stays 2 and the pointers wrap correctly after 2*DEPTH operations.
REQ-038 SHALL verify that pushing 0x7FFFFFFF then 1 sets ovf=1; acc_total=0x80000000 without SAT_EN and 0x7FFFFFFF with it.
REQ-039 SHALL verify that asserting reset asynchronously mid-cycle with count=3 immediately gives count=0, out_valid=0, acc_total=0, ovf=0.
REQ-040 SHALL verify that clear asserted together with in_valid drops the push, and that the next cycle shows count=0 and acc_total=0.
